// File: rtl/sd_drive_arbiter.sv
// Shares the single user_io SD block interface between floppy slots A: and B:.
// Round-robin grant, registered sd_rd/sd_wr/sd_lba, ack handshake tracking and buffer steering.
module sd_drive_arbiter #(
  parameter int unsigned TIMEOUT_W = 24,
  parameter int unsigned TIMEOUT   = 16000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [63:0] req_lba,
  input  logic [1:0]  req_rd,
  input  logic [1:0]  req_wr,
  output logic [1:0]  req_done,
  output logic [1:0]  req_err,
  output logic [1:0]  req_buff_wr,
  input  logic [15:0] req_buff_din,
  output logic [31:0] sd_lba,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic        busy,
  output logic        grant
);

  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic                 TO_EN   = (TIMEOUT != 0);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_DONE, S_FAIL} state_t;

  state_t                r_state;
  logic                  r_last;
  logic [TIMEOUT_W-1:0]  r_cnt;

  logic [1:0]  w_pend;
  logic        w_pick;
  logic [1:0]  w_pick_oh;
  logic [1:0]  w_grant_oh;
  logic        w_timeout;

  // Arbitration: a lone requester wins; on contention the drive not served last wins.
  always_comb begin
    w_pend = req_rd | req_wr;
    if (w_pend == 2'b11) w_pick = ~r_last;
    else                 w_pick = w_pend[1];
    w_pick_oh  = w_pick ? 2'b10 : 2'b01;
    w_grant_oh = grant  ? 2'b10 : 2'b01;
    w_timeout  = TO_EN && (r_cnt == TO_LAST);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_cnt    <= '0;
      sd_lba   <= '0;
      sd_rd    <= '0;
      sd_wr    <= '0;
      req_done <= '0;
      req_err  <= '0;
      busy     <= 1'b0;
      grant    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pend != 2'b00) begin
            grant   <= w_pick;
            sd_lba  <= w_pick ? req_lba[63:32] : req_lba[31:0];
            // Write wins when a drive asserts both read and write.
            if (req_wr[w_pick]) begin
              sd_wr <= w_pick_oh;
              sd_rd <= 2'b00;
            end else begin
              sd_rd <= w_pick_oh;
              sd_wr <= 2'b00;
            end
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + TIMEOUT_W'(1);
          if (sd_ack) begin
            sd_rd   <= 2'b00;
            sd_wr   <= 2'b00;
            r_state <= S_XFER;
          end else if (w_timeout) begin
            sd_rd   <= 2'b00;
            sd_wr   <= 2'b00;
            req_err <= w_grant_oh;
            r_state <= S_FAIL;
          end
        end
        S_XFER: begin
          if (!sd_ack) begin
            req_done <= w_grant_oh;
            r_state  <= S_DONE;
          end
        end
        S_DONE, S_FAIL: begin
          req_done <= 2'b00;
          req_err  <= 2'b00;
          r_last   <= grant;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Buffer steering: strobes reach only the granted drive and only while transferring.
  always_comb begin
    req_buff_wr = 2'b00;
    if (r_state == S_XFER && sd_buff_wr) req_buff_wr = w_grant_oh;
    sd_buff_din = grant ? req_buff_din[15:8] : req_buff_din[7:0];
  end

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// Directed bench for sd_drive_arbiter: handshake, round-robin, write steering, timeout, reset.
module tb_sd_drive_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [63:0] req_lba;
  logic [1:0]  req_rd, req_wr;
  logic [1:0]  req_done, req_err, req_buff_wr;
  logic [15:0] req_buff_din;
  logic [31:0] sd_lba;
  logic [1:0]  sd_rd, sd_wr;
  logic        sd_ack, sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic        busy, grant;

  int total = 0;
  int bad   = 0;
  int n0, n1;

  sd_drive_arbiter #(.TIMEOUT_W(24), .TIMEOUT(16)) dut (
    .clk_sys(clk_sys), .reset(reset), .req_lba(req_lba), .req_rd(req_rd), .req_wr(req_wr),
    .req_done(req_done), .req_err(req_err), .req_buff_wr(req_buff_wr),
    .req_buff_din(req_buff_din), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .busy(busy), .grant(grant)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called one negedge after the grant edge; returns with the DUT back in IDLE.
  task automatic handshake(input string tag, input logic g, input logic [1:0] erd,
                           input logic [1:0] ewr, input logic [31:0] elba, input bit drop);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_sd_rd"}, 32'(sd_rd), 32'(erd));
    chk({tag, "_sd_wr"}, 32'(sd_wr), 32'(ewr));
    chk({tag, "_lba"}, sd_lba, elba);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    sd_ack = 1'b1;
    tick();
    chk({tag, "_req_drop"}, 32'({sd_rd, sd_wr}), 32'd0);
    sd_ack = 1'b0;
    tick();
    chk({tag, "_done"}, 32'(req_done), g ? 32'd2 : 32'd1);
    if (drop) begin
      req_rd = 2'b00;
      req_wr = 2'b00;
    end
    tick();
    chk({tag, "_done_end"}, 32'(req_done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_lba = '0; req_rd = '0; req_wr = '0; req_buff_din = '0;
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    tick(); tick();
    chk("rst_sd_rd", 32'(sd_rd), 32'd0);
    chk("rst_sd_wr", 32'(sd_wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_lba", sd_lba, 32'd0);
    chk("rst_pulses", 32'({req_done, req_err}), 32'd0);
    reset = 1'b0;
    tick();

    // Stray strobe in IDLE
    sd_buff_wr = 1'b1; #1;
    chk("stray_idle", 32'(req_buff_wr), 32'd0);
    sd_buff_wr = 1'b0;

    // Single read on drive 0 with 512 strobes
    req_lba = {32'h0000_0BBB, 32'h0000_0123};
    req_rd  = 2'b01;
    tick();
    chk("rd_sd_rd", 32'(sd_rd), 32'd1);
    chk("rd_lba", sd_lba, 32'h123);
    chk("rd_busy", 32'(busy), 32'd1);
    sd_buff_wr = 1'b1; #1;
    chk("stray_req", 32'(req_buff_wr), 32'd0);
    sd_buff_wr = 1'b0;
    sd_ack = 1'b1;
    tick();
    chk("rd_xfer_drop", 32'(sd_rd), 32'd0);
    n0 = 0; n1 = 0;
    repeat (512) begin
      sd_buff_wr = 1'b1; #1;
      if (req_buff_wr[0]) n0++;
      if (req_buff_wr[1]) n1++;
      tick();
    end
    sd_buff_wr = 1'b0;
    chk("rd_strobes0", 32'(n0), 32'd512);
    chk("rd_strobes1", 32'(n1), 32'd0);
    sd_ack = 1'b0;
    tick();
    chk("rd_done", 32'(req_done), 32'd1);
    chk("rd_done_err", 32'(req_err), 32'd0);
    req_rd = 2'b00;
    tick();
    chk("rd_done_end", 32'(req_done), 32'd0);
    chk("rd_idle", 32'(busy), 32'd0);
    chk("rd_grant_hold", 32'(grant), 32'd0);

    // Contention out of reset, both held: strict alternation 0,1,0,1
    reset = 1'b1; tick(); reset = 1'b0;
    req_lba = {32'h0000_00B1, 32'h0000_00A0};
    req_rd  = 2'b11;
    tick(); handshake("rr0", 1'b0, 2'b01, 2'b00, 32'hA0, 1'b0);
    tick(); handshake("rr1", 1'b1, 2'b10, 2'b00, 32'hB1, 1'b0);
    tick(); handshake("rr2", 1'b0, 2'b01, 2'b00, 32'hA0, 1'b0);
    tick(); handshake("rr3", 1'b1, 2'b10, 2'b00, 32'hB1, 1'b1);

    // Write steering on drive 1, then read+write on drive 0 (write wins)
    req_buff_din = 16'hA53C;
    req_wr = 2'b10;
    tick();
    chk("wr1_din", 32'(sd_buff_din), 32'hA5);
    handshake("wr1", 1'b1, 2'b00, 2'b10, 32'hB1, 1'b1);
    req_rd = 2'b01; req_wr = 2'b01;
    tick();
    chk("wr0_din", 32'(sd_buff_din), 32'h3C);
    handshake("wr0", 1'b0, 2'b00, 2'b01, 32'hA0, 1'b1);

    // Timeout: 16 REQ cycles with no ack
    req_rd = 2'b01;
    tick();
    chk("to_first", 32'(sd_rd), 32'd1);
    repeat (15) tick();
    chk("to_last", 32'(sd_rd), 32'd1);
    chk("to_no_err_yet", 32'(req_err), 32'd0);
    tick();
    chk("to_drop", 32'(sd_rd), 32'd0);
    chk("to_err", 32'(req_err), 32'd1);
    chk("to_no_done", 32'(req_done), 32'd0);
    req_rd = 2'b00;
    tick();
    chk("to_err_end", 32'(req_err), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);
    req_rd = 2'b01;
    tick(); handshake("to_next", 1'b0, 2'b01, 2'b00, 32'hA0, 1'b1);

    // Reset mid-XFER on drive 1, then drive 0 priority
    req_rd = 2'b10;
    tick();
    chk("rx_grant", 32'(grant), 32'd1);
    sd_ack = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    chk("rx_outs", 32'({sd_rd, sd_wr, req_done, req_err}), 32'd0);
    chk("rx_busy", 32'(busy), 32'd0);
    chk("rx_grant0", 32'(grant), 32'd0);
    chk("rx_lba", sd_lba, 32'd0);
    reset = 1'b0; sd_ack = 1'b0;
    req_rd = 2'b11;
    tick(); handshake("rx_next", 1'b0, 2'b01, 2'b00, 32'hA0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
